// File: rtl/mole_board.sv
// rtl/mole_board.sv - active-mole board with per-hole lifetimes and hit/miss/whiff reporting
module mole_board #(
  parameter int N_HOLES = 5,
  parameter int LIFE_W  = 8,
  localparam int CNT_W  = $clog2(N_HOLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               load,
  input  logic [N_HOLES-1:0] loadval,
  input  logic [LIFE_W-1:0]  life_ticks,
  input  logic [N_HOLES-1:0] button,
  output logic [N_HOLES-1:0] board_state,
  output logic               hit_pulse,
  output logic [CNT_W-1:0]   hit_count,
  output logic               miss_pulse,
  output logic [CNT_W-1:0]   miss_count,
  output logic               whiff_pulse,
  output logic [CNT_W-1:0]   active_count
);

  logic [N_HOLES-1:0] board_q, board_d;
  logic [LIFE_W-1:0]  life_q [N_HOLES];
  logic [LIFE_W-1:0]  life_d [N_HOLES];
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic [CNT_W-1:0]   miss_count_q, miss_count_d;
  logic [CNT_W-1:0]   active_count_q, active_count_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic               whiff_pulse_q, whiff_pulse_d;

  logic [N_HOLES-1:0] hit_v, whiff_v, spawn_v, expire_v;

  assign hit_v   = button & board_q;
  assign whiff_v = button & ~board_q;
  assign spawn_v = {N_HOLES{load}} & loadval;

  // A life of zero on an active hole never reaches 1, so it never expires.
  always_comb begin
    expire_v = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      expire_v[i] = board_q[i] & ~hit_v[i] & tick & (life_q[i] == LIFE_W'(1));
    end
  end

  always_comb begin
    board_d        = board_q;
    hit_count_d    = '0;
    miss_count_d   = '0;
    active_count_d = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      life_d[i] = life_q[i];
      if (spawn_v[i]) begin
        board_d[i] = 1'b1;
        life_d[i]  = life_ticks;
      end else if (hit_v[i] || expire_v[i]) begin
        board_d[i] = 1'b0;
        life_d[i]  = '0;
      end else if (board_q[i] && tick && (life_q[i] > LIFE_W'(1))) begin
        life_d[i] = life_q[i] - LIFE_W'(1);
      end
      hit_count_d    = hit_count_d + CNT_W'(hit_v[i]);
      miss_count_d   = miss_count_d + CNT_W'(expire_v[i]);
      active_count_d = active_count_d + CNT_W'(board_d[i]);
    end
    hit_pulse_d   = (hit_count_d != '0);
    miss_pulse_d  = (miss_count_d != '0);
    whiff_pulse_d = |whiff_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q        <= '0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      active_count_q <= '0;
      hit_pulse_q    <= 1'b0;
      miss_pulse_q   <= 1'b0;
      whiff_pulse_q  <= 1'b0;
      for (int i = 0; i < N_HOLES; i++) life_q[i] <= '0;
    end else begin
      board_q        <= board_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
      active_count_q <= active_count_d;
      hit_pulse_q    <= hit_pulse_d;
      miss_pulse_q   <= miss_pulse_d;
      whiff_pulse_q  <= whiff_pulse_d;
      for (int i = 0; i < N_HOLES; i++) life_q[i] <= life_d[i];
    end
  end

  assign board_state  = board_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;
  assign active_count = active_count_q;
  assign hit_pulse    = hit_pulse_q;
  assign miss_pulse   = miss_pulse_q;
  assign whiff_pulse  = whiff_pulse_q;

endmodule

// File: tb/tb_mole_board.sv
// tb/tb_mole_board.sv - randomized and directed checks of mole_board against a behavioural model
module tb_mole_board;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [4:0] loadval = '0;
  logic [7:0] life_ticks = '0;
  logic [4:0] button = '0;
  logic [4:0] board_state;
  logic       hit_pulse, miss_pulse, whiff_pulse;
  logic [2:0] hit_count, miss_count, active_count;

  logic        load16 = 1'b0;
  logic [15:0] loadval16 = '0;
  logic [15:0] button16 = '0;
  logic [15:0] board16;
  logic        hit_pulse16, miss_pulse16, whiff_pulse16;
  logic [4:0]  hit_count16, miss_count16, active_count16;

  int n_vec = 0;
  int n_err = 0;

  bit m_act [5];
  int m_life [5];
  int exp_hit, exp_miss, exp_active;
  bit exp_whiff;

  always #5 clk = ~clk;

  mole_board dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .loadval(loadval),
    .life_ticks(life_ticks), .button(button), .board_state(board_state),
    .hit_pulse(hit_pulse), .hit_count(hit_count), .miss_pulse(miss_pulse),
    .miss_count(miss_count), .whiff_pulse(whiff_pulse), .active_count(active_count)
  );

  mole_board #(.N_HOLES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .tick(1'b0), .load(load16), .loadval(loadval16),
    .life_ticks(8'd0), .button(button16), .board_state(board16),
    .hit_pulse(hit_pulse16), .hit_count(hit_count16), .miss_pulse(miss_pulse16),
    .miss_count(miss_count16), .whiff_pulse(whiff_pulse16), .active_count(active_count16)
  );

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_act[i] = 0;
      m_life[i] = 0;
    end
    exp_hit = 0; exp_miss = 0; exp_active = 0; exp_whiff = 0;
  endfunction

  // Applies the game rules for one clock edge using the inputs present at that edge.
  function automatic void model_update();
    bit h, e, s;
    exp_hit = 0; exp_miss = 0; exp_whiff = 0; exp_active = 0;
    for (int i = 0; i < 5; i++) begin
      h = button[i] && m_act[i];
      if (button[i] && !m_act[i]) exp_whiff = 1;
      e = m_act[i] && !h && tick && (m_life[i] == 1);
      s = load && loadval[i];
      exp_hit += int'(h);
      exp_miss += int'(e);
      if (s) begin
        m_act[i] = 1;
        m_life[i] = int'(life_ticks);
      end else if (h || e) begin
        m_act[i] = 0;
        m_life[i] = 0;
      end else if (m_act[i] && tick && m_life[i] > 1) begin
        m_life[i]--;
      end
      exp_active += int'(m_act[i]);
    end
  endfunction

  function automatic logic [4:0] model_board();
    logic [4:0] b;
    for (int i = 0; i < 5; i++) b[i] = m_act[i];
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic ld, input logic [4:0] lv, input logic [7:0] lt,
                        input logic tk, input logic [4:0] bt);
    load = ld; loadval = lv; life_ticks = lt; tick = tk; button = bt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0);
    load16 = 0; loadval16 = '0; button16 = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({board_state, hit_count, miss_count, active_count, hit_pulse, miss_pulse, whiff_pulse} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got board=%b hit=%0d miss=%0d act=%0d pulses=%b%b%b want all 0",
               board_state, hit_count, miss_count, active_count, hit_pulse, miss_pulse, whiff_pulse);
    end
    n_vec++;
    if ({board16, hit_count16, active_count16} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs16: got board=%h hit=%0d act=%0d want 0", board16, hit_count16, active_count16);
    end
  endtask

  task automatic test_basic_hit();
    do_reset();
    set_in(1, 5'b10101, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 5'b00100);
    step();
    n_vec++;
    if (board_state !== 5'b10001 || hit_count !== 3'd1 || hit_pulse !== 1'b1 || active_count !== 3'd2) begin
      n_err++;
      $display("FAIL basic_hit: got board=%b hit=%0d hp=%b act=%0d want board=10001 hit=1 hp=1 act=2",
               board_state, hit_count, hit_pulse, active_count);
    end
  endtask

  task automatic test_expiry();
    int fell;
    logic [2:0] mc;
    do_reset();
    set_in(1, 5'b00010, 8'd3, 0, 0);
    step();
    set_in(0, 0, 0, 1, 0);
    fell = 0;
    mc = '0;
    for (int k = 1; k <= 10 && fell == 0; k++) begin
      step();
      if (!board_state[1]) begin
        fell = k;
        mc = miss_count;
      end
    end
    n_vec++;
    if (fell != 3) begin
      n_err++;
      $display("FAIL expiry_edge: got fell on tick %0d want 3", fell);
    end
    n_vec++;
    if (mc !== 3'd1) begin
      n_err++;
      $display("FAIL expiry_miss: got miss_count=%0d want 1", mc);
    end
    step();
    n_vec++;
    if (miss_count !== 3'd0 || miss_pulse !== 1'b0 || board_state[1] !== 1'b0) begin
      n_err++;
      $display("FAIL expiry_after: got miss=%0d mp=%b b1=%b want 0 0 0", miss_count, miss_pulse, board_state[1]);
    end
  endtask

  task automatic test_hit_beats_expiry();
    do_reset();
    set_in(1, 5'b00001, 8'd1, 0, 0);
    step();
    set_in(0, 0, 0, 1, 5'b00001);
    step();
    n_vec++;
    if (hit_count !== 3'd1 || miss_count !== 3'd0 || board_state[0] !== 1'b0) begin
      n_err++;
      $display("FAIL hit_vs_expire: got hit=%0d miss=%0d b0=%b want 1 0 0", hit_count, miss_count, board_state[0]);
    end
  endtask

  task automatic test_multi_hit_whiff();
    do_reset();
    set_in(1, 5'b00011, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 5'b01011);
    step();
    n_vec++;
    if (hit_count !== 3'd2 || whiff_pulse !== 1'b1 || board_state !== 5'b00000) begin
      n_err++;
      $display("FAIL multi_hit: got hit=%0d whiff=%b board=%b want 2 1 00000", hit_count, whiff_pulse, board_state);
    end
  endtask

  task automatic test_hit_respawn();
    int fell;
    do_reset();
    set_in(1, 5'b00100, 8'd2, 0, 0);
    step();
    set_in(1, 5'b00100, 8'd7, 0, 5'b00100);
    step();
    n_vec++;
    if (hit_count !== 3'd1 || board_state[2] !== 1'b1) begin
      n_err++;
      $display("FAIL respawn_hit: got hit=%0d b2=%b want 1 1", hit_count, board_state[2]);
    end
    set_in(0, 0, 0, 1, 0);
    fell = 0;
    for (int k = 1; k <= 12 && fell == 0; k++) begin
      step();
      if (!board_state[2]) fell = k;
    end
    n_vec++;
    if (fell != 7) begin
      n_err++;
      $display("FAIL respawn_life: got expiry on tick %0d want 7", fell);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    set_in(1, 5'b11111, 8'd10, 0, 0);
    step();
    set_in(0, 0, 0, 1, 0);
    step();
    set_in(0, 0, 0, 1, 5'b00001);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({board_state, hit_count, miss_count, active_count, hit_pulse, miss_pulse, whiff_pulse} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got board=%b hit=%0d act=%0d hp=%b want all 0",
               board_state, hit_count, active_count, hit_pulse);
    end
    @(negedge clk);
    set_in(0, 0, 0, 1, 0);
    model_reset();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (hit_count !== 0 || miss_count !== 0 || hit_pulse !== 0 || miss_pulse !== 0 || board_state !== 0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL post_reset_quiet: got %0d cycles with activity want 0", bad);
    end
  endtask

  task automatic test_all16();
    do_reset();
    load16 = 1; loadval16 = 16'hFFFF;
    @(negedge clk);
    load16 = 0; loadval16 = '0; button16 = 16'hFFFF;
    @(negedge clk);
    button16 = '0;
    n_vec++;
    if (hit_count16 !== 5'd16 || hit_pulse16 !== 1'b1 || board16 !== 16'h0 || active_count16 !== 5'd0) begin
      n_err++;
      $display("FAIL all16_hit: got hit=%0d hp=%b board=%h act=%0d want 16 1 0000 0",
               hit_count16, hit_pulse16, board16, active_count16);
    end
  endtask

  task automatic test_random();
    logic [16:0] got, want;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      set_in(($urandom_range(0, 3) == 0), 5'($urandom), 8'($urandom_range(0, 4)),
             $urandom_range(0, 1) == 1, 5'($urandom) & 5'($urandom) & 5'($urandom));
      step();
      got  = {board_state, hit_count, miss_count, whiff_pulse, active_count, hit_pulse, miss_pulse};
      want = {model_board(), 3'(exp_hit), 3'(exp_miss), exp_whiff, 3'(exp_active),
              exp_hit != 0, exp_miss != 0};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %b want %b (board,hit,miss,whiff,active,hp,mp)", k, got, want);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_hit();
    test_expiry();
    test_hit_beats_expiry();
    test_multi_hit_whiff();
    test_hit_respawn();
    test_async_reset();
    test_all16();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mole_board.md
Name: mole_board

Overview:
- Parametrised successor of the five-hole board-state register.
- Holds the set of active moles for N_HOLES holes. Each active mole carries its own lifetime countdown.
- Reports hits, expiries (misses) and empty-hole presses (whiffs) as registered per-cycle counts and pulses.
- Sits between the mole spawner/LFSR (drives load/loadval) and the score/display logic (consumes board_state and the count outputs).

Parameters:
- N_HOLES, 5, number of holes/moles, valid range 1..16.
- LIFE_W, 8, width of per-mole lifetime counter and of life_ticks.
- CNT_W, $clog2(N_HOLES+1), width of per-cycle count outputs (derived; do not override).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  game-time enable; lifetimes decrement only when high
- load  input  1  active-high spawn strobe
- loadval  input  N_HOLES  holes to spawn on this load (active high)
- life_ticks  input  LIFE_W  lifetime in ticks given to moles spawned this cycle; 0 = never expires
- button  input  N_HOLES  active-high per-hole press pulse
- board_state  output  N_HOLES  active moles (registered)
- hit_pulse  output  1  high for one cycle when hit_count != 0
- hit_count  output  CNT_W  number of moles hit in the previous cycle
- miss_pulse  output  1  high for one cycle when miss_count != 0
- miss_count  output  CNT_W  number of moles expired in the previous cycle
- whiff_pulse  output  1  high one cycle if any button pressed an inactive hole in the previous cycle
- active_count  output  CNT_W  popcount of board_state (registered, consistent with board_state)

Behaviour:
- Reset (async assert, sync release):
  - board_state = 0, all lifetime counters = 0.
  - All pulses and counts = 0; active_count = 0.
- Per hole i, with board_state[i] and life[i] as the current (pre-edge) values:
  - hit_i = button[i] & board_state[i]
  - whiff_i = button[i] & ~board_state[i]
  - expire_i = board_state[i] & ~hit_i & tick & (life[i]==1)
  - spawn_i = load & loadval[i]
- Next state:
  - If spawn_i: active = 1, life = life_ticks. A spawn overrides any hit or expiry in the same cycle.
  - Else if hit_i or expire_i: active = 0, life = 0.
  - Else if active & tick & life>1: life decrements.
  - life == 0 while active means infinite lifetime: never decrements, never expires.
- Outputs, all registered (latency 1 cycle from the causing edge):
  - hit_count = popcount(hit), miss_count = popcount(expire).
  - whiff_pulse = |whiff; pulses follow the corresponding count != 0.
- Simultaneous events:
  - Hit and expiry on the same hole in the same cycle: the hit wins; no miss is counted.
  - Hit or expiry plus spawn on the same hole: the event is counted and the mole is re-spawned with a fresh lifetime.
  - Spawn on an already-active hole without a hit: lifetime restarts, nothing is counted.
  - Spawn and button in the same cycle on an inactive hole: counts as a whiff; mole becomes active.
- Button held high for k cycles on an active hole: 1 hit, then k-1 whiffs. Callers must supply single-cycle pulses.
- Multiple holes hit in one cycle are all counted. hit_count can reach N_HOLES without overflow (CNT_W sized for N_HOLES).
- board_state and active_count update on the same edge. No combinational path from inputs to outputs.
- Reset asserted mid-game clears everything immediately. No pulse is emitted for moles cleared by reset.

Test Plan:
- Reset; load=1, loadval=5'b10101, life_ticks=0, then button=5'b00100 → next cycle board_state=5'b10001, hit_count=1, hit_pulse=1, active_count=2.
- Spawn hole 1 with life_ticks=3, then tick high continuously, no buttons → board_state[1] falls on the 3rd tick edge; miss_count=1 for exactly one cycle; hole 1 stays inactive.
- Hole 0 active with life=1, same cycle tick=1 and button[0]=1 → hit_count=1, miss_count=0, board_state[0]=0.
- board_state=5'b00011, button=5'b01011 → hit_count=2 and whiff_pulse=1 together; board_state=5'b00000.
- Hole 2 active, same cycle button[2]=1, load=1, loadval=5'b00100, life_ticks=7 → hit_count=1; board_state[2] stays 1 with lifetime 7. Confirm by observing expiry 7 ticks later.
- Moles active with counters mid-countdown, assert rst_n=0 asynchronously between edges → all outputs 0 immediately; no miss/hit pulses after release; N_HOLES=16 build with all 16 hit in one cycle → hit_count=16.
